// File: rtl/traffic_light_fsm.sv
// Traffic-light controller: sequences main/side road lights and the pedestrian
// walk phase, timing each state from the interval value returned by TimeParameters.
module traffic_light_fsm #(
  parameter int unsigned TW       = 4,
  parameter logic [1:0]  INT_BASE = 2'b00,
  parameter logic [1:0]  INT_EXT  = 2'b01,
  parameter logic [1:0]  INT_YEL  = 2'b10
) (
  input  logic          clk,
  input  logic          global_reset,
  input  logic          one_hz_enable,
  input  logic          sensor,
  input  logic          walk_request,
  input  logic          reprogram,
  input  logic [TW-1:0] output_time_value,
  output logic [1:0]    fsm_requested_interval,
  output logic [2:0]    main_lights,
  output logic [2:0]    side_lights,
  output logic          walk_light,
  output logic          expired
);

  typedef enum logic [2:0] {
    S_MG1  = 3'd0,
    S_MG2  = 3'd1,
    S_MY   = 3'd2,
    S_WALK = 3'd3,
    S_SG   = 3'd4,
    S_SGX  = 3'd5,
    S_SY   = 3'd6
  } state_t;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  state_t        state_q, state_d;
  logic          count_q, count_d;   // 0 = LOAD phase, 1 = COUNT phase
  logic [TW-1:0] counter_q, counter_d;
  logic          latch_q, latch_d;
  logic          expired_d;
  logic [1:0]    code_d;
  logic [2:0]    main_d, side_d;
  logic          walk_d;

  // State register plus registered outputs
  always_ff @(posedge clk or negedge global_reset) begin
    if (!global_reset) begin
      state_q                <= S_MG1;
      count_q                <= 1'b0;
      counter_q              <= '0;
      latch_q                <= 1'b0;
      expired                <= 1'b0;
      fsm_requested_interval <= INT_BASE;
      main_lights            <= LT_GRN;
      side_lights            <= LT_RED;
      walk_light             <= 1'b0;
    end else begin
      state_q                <= state_d;
      count_q                <= count_d;
      counter_q              <= counter_d;
      latch_q                <= latch_d;
      expired                <= expired_d;
      fsm_requested_interval <= code_d;
      main_lights            <= main_d;
      side_lights            <= side_d;
      walk_light             <= walk_d;
    end
  end

  // Next-state: LOAD samples the interval, COUNT runs it down on ticks
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    counter_d = counter_q;
    latch_d   = latch_q | walk_request;
    expired_d = 1'b0;
    if (reprogram) begin
      state_d   = S_MG1;
      count_d   = 1'b0;
      counter_d = '0;
    end else if (!count_q) begin
      count_d   = 1'b1;
      counter_d = output_time_value;
    end else if (one_hz_enable) begin
      if (counter_q > TW'(1)) begin
        counter_d = counter_q - TW'(1);
      end else begin
        expired_d = 1'b1;
        count_d   = 1'b0;
        counter_d = '0;
        case (state_q)
          S_MG1:   state_d = S_MG2;
          S_MG2:   state_d = (sensor || latch_q) ? S_MY : S_MG2;
          S_MY:    state_d = latch_q ? S_WALK : S_SG;
          S_WALK:  state_d = S_SG;
          S_SG:    state_d = sensor ? S_SGX : S_SY;
          S_SGX:   state_d = S_SY;
          S_SY:    state_d = S_MG1;
          default: state_d = S_MG1;
        endcase
        // A request on the entry cycle itself must survive the clear
        if (state_d == S_WALK) latch_d = walk_request;
      end
    end
  end

  // Output decode of the upcoming state
  always_comb begin
    code_d = INT_BASE;
    main_d = LT_RED;
    side_d = LT_RED;
    walk_d = 1'b0;
    case (state_d)
      S_MG1, S_MG2: begin code_d = INT_BASE; main_d = LT_GRN; end
      S_MY:         begin code_d = INT_YEL;  main_d = LT_YEL; end
      S_WALK:       begin code_d = INT_EXT;  walk_d = 1'b1;   end
      S_SG:         begin code_d = INT_BASE; side_d = LT_GRN; end
      S_SGX:        begin code_d = INT_EXT;  side_d = LT_GRN; end
      S_SY:         begin code_d = INT_YEL;  side_d = LT_YEL; end
      default:      begin code_d = INT_BASE; main_d = LT_GRN; end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: table of {inputs, cycle count, expected outputs}
// plus hand sequences for a zero-length interval and an asynchronous reset.
module tb_traffic_light_fsm;

  localparam logic [1:0] B  = 2'b00;
  localparam logic [1:0] E  = 2'b01;
  localparam logic [1:0] Y  = 2'b10;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] YL = 3'b010;
  localparam logic [2:0] R  = 3'b100;

  typedef struct {
    int unsigned n;
    logic        tick;
    logic        sensor;
    logic        walk;
    logic        reprog;
    logic [1:0]  code;
    logic [2:0]  main;
    logic [2:0]  side;
    logic        wlk;
    logic        exp_p;
  } vec_t;

  logic       clk = 1'b0;
  logic       global_reset;
  logic       one_hz_enable;
  logic       sensor;
  logic       walk_request;
  logic       reprogram;
  logic [3:0] output_time_value;
  logic [1:0] fsm_requested_interval;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk_light;
  logic       expired;

  logic [3:0] t_base = 4'd6;
  logic [3:0] t_ext  = 4'd3;
  logic [3:0] t_yel  = 4'd2;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  vec_t        vecs[$];

  traffic_light_fsm dut (
    .clk                    (clk),
    .global_reset           (global_reset),
    .one_hz_enable          (one_hz_enable),
    .sensor                 (sensor),
    .walk_request           (walk_request),
    .reprogram              (reprogram),
    .output_time_value      (output_time_value),
    .fsm_requested_interval (fsm_requested_interval),
    .main_lights            (main_lights),
    .side_lights            (side_lights),
    .walk_light             (walk_light),
    .expired                (expired)
  );

  always #5 clk = ~clk;

  // TimeParameters store model
  always_comb begin
    case (fsm_requested_interval)
      B:       output_time_value = t_base;
      E:       output_time_value = t_ext;
      Y:       output_time_value = t_yel;
      default: output_time_value = 4'd0;
    endcase
  end

  task automatic add(input int unsigned n, input logic t, input logic s, input logic w,
                     input logic rp, input logic [1:0] c, input logic [2:0] m,
                     input logic [2:0] sd, input logic wl, input logic ex);
    vec_t v;
    v.n = n; v.tick = t; v.sensor = s; v.walk = w; v.reprog = rp;
    v.code = c; v.main = m; v.side = sd; v.wlk = wl; v.exp_p = ex;
    vecs.push_back(v);
  endtask

  task automatic step(input int unsigned n, input logic t, input logic s,
                      input logic w, input logic rp);
    for (int unsigned i = 0; i < n; i++) begin
      one_hz_enable = t;
      sensor        = s;
      walk_request  = w;
      reprogram     = rp;
      @(posedge clk);
      @(negedge clk);
    end
    one_hz_enable = 1'b0;
    walk_request  = 1'b0;
    reprogram     = 1'b0;
  endtask

  task automatic chk(input string name, input logic [1:0] c, input logic [2:0] m,
                     input logic [2:0] sd, input logic wl, input logic ex);
    n_vec++;
    if (fsm_requested_interval !== c || main_lights !== m || side_lights !== sd ||
        walk_light !== wl || expired !== ex) begin
      n_bad++;
      $display("FAIL %s: got code=%b main=%b side=%b walk=%b exp=%b, want code=%b main=%b side=%b walk=%b exp=%b",
               name, fsm_requested_interval, main_lights, side_lights, walk_light, expired,
               c, m, sd, wl, ex);
    end
  endtask

  initial begin
    //   n  tk s  w  rp code main side wl ex
    add(1, 1, 0, 0, 0, B, G,  R,  0, 0);  // MG1 count
    add(5, 1, 0, 0, 0, B, G,  R,  0, 0);
    add(1, 1, 0, 0, 0, B, G,  R,  0, 1);  // MG1 -> MG2 after 6 ticks
    add(1, 1, 0, 0, 0, B, G,  R,  0, 0);
    add(5, 1, 0, 0, 0, B, G,  R,  0, 0);
    add(1, 1, 0, 0, 0, B, G,  R,  0, 1);  // MG2 reloads
    add(6, 1, 1, 0, 0, B, G,  R,  0, 0);
    add(1, 1, 1, 0, 0, Y, YL, R,  0, 1);  // MY
    add(1, 1, 0, 0, 0, Y, YL, R,  0, 0);
    add(1, 1, 0, 0, 0, Y, YL, R,  0, 0);
    add(1, 1, 0, 0, 0, B, R,  G,  0, 1);  // SG
    add(7, 1, 1, 0, 0, E, R,  G,  0, 1);  // SGX
    add(4, 1, 0, 0, 0, Y, R,  YL, 0, 1);  // SY
    add(3, 1, 0, 0, 0, B, G,  R,  0, 1);  // MG1
    add(1, 1, 0, 1, 0, B, G,  R,  0, 0);  // walk pulse
    add(6, 1, 0, 0, 0, B, G,  R,  0, 1);
    add(7, 1, 0, 0, 0, Y, YL, R,  0, 1);  // latch forces MY
    add(3, 1, 0, 0, 0, E, R,  R,  1, 1);  // WALK
    add(4, 1, 0, 0, 0, B, R,  G,  0, 1);  // SG
    add(7, 1, 0, 0, 0, Y, R,  YL, 0, 1);
    add(3, 1, 0, 0, 0, B, G,  R,  0, 1);
    add(7, 1, 0, 0, 0, B, G,  R,  0, 1);
    add(7, 1, 0, 0, 0, B, G,  R,  0, 1);  // latch cleared: MG2 reloads
    add(3, 0, 0, 0, 0, B, G,  R,  0, 0);  // no ticks: hold
    add(6, 1, 0, 0, 0, B, G,  R,  0, 1);
    add(7, 1, 1, 0, 0, Y, YL, R,  0, 1);
    add(3, 1, 0, 0, 0, B, R,  G,  0, 1);
    add(3, 1, 0, 0, 0, B, R,  G,  0, 0);  // SG counter = 4
    add(1, 1, 0, 0, 1, B, G,  R,  0, 0);  // reprogram
    add(1, 1, 0, 0, 0, B, G,  R,  0, 0);
    add(6, 1, 0, 0, 0, B, G,  R,  0, 1);
    add(7, 1, 1, 0, 0, Y, YL, R,  0, 1);
    add(3, 1, 0, 0, 0, B, R,  G,  0, 1);
    add(6, 1, 1, 0, 0, B, R,  G,  0, 0);  // SG counter = 1
    add(1, 1, 1, 0, 1, B, G,  R,  0, 0);  // reprogram beats expiry
    add(1, 1, 0, 1, 1, B, G,  R,  0, 0);  // walk during reprogram
    add(7, 1, 0, 0, 0, B, G,  R,  0, 1);
    add(7, 1, 0, 0, 0, Y, YL, R,  0, 1);  // latch survived reprogram
    add(3, 1, 0, 1, 0, E, R,  R,  1, 1);  // request on entry cycle
    add(4, 1, 0, 0, 0, B, R,  G,  0, 1);
    add(7, 1, 0, 0, 0, Y, R,  YL, 0, 1);
    add(3, 1, 0, 0, 0, B, G,  R,  0, 1);
    add(7, 1, 0, 0, 0, B, G,  R,  0, 1);
    add(7, 1, 0, 0, 0, Y, YL, R,  0, 1);  // set-wins latch forces MY
    add(3, 1, 0, 0, 0, E, R,  R,  1, 1);
    add(4, 1, 0, 0, 0, B, R,  G,  0, 1);

    global_reset  = 1'b0;
    one_hz_enable = 1'b0;
    sensor        = 1'b0;
    walk_request  = 1'b0;
    reprogram     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", B, G, R, 0, 0);
    global_reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].n, vecs[i].tick, vecs[i].sensor, vecs[i].walk, vecs[i].reprog);
      chk($sformatf("vec%0d", i), vecs[i].code, vecs[i].main, vecs[i].side,
          vecs[i].wlk, vecs[i].exp_p);
    end

    // Zero yellow interval behaves as one tick
    step(7, 1, 0, 0, 0); chk("to_sy", Y, R, YL, 0, 1);
    step(3, 1, 0, 0, 0); chk("to_mg1", B, G, R, 0, 1);
    step(7, 1, 0, 0, 0); chk("to_mg2", B, G, R, 0, 1);
    step(7, 1, 1, 0, 0); chk("to_my", Y, YL, R, 0, 1);
    t_yel = 4'd0;
    step(1, 1, 0, 0, 0); chk("yel0_count", Y, YL, R, 0, 0);
    step(1, 1, 0, 0, 0); chk("yel0_expire", B, R, G, 0, 1);
    t_yel = 4'd2;

    // Asynchronous reset mid-SGX
    step(7, 1, 1, 0, 0); chk("to_sgx", E, R, G, 0, 1);
    step(2, 1, 0, 0, 0); chk("sgx_mid", E, R, G, 0, 0);
    one_hz_enable = 1'b1;
    global_reset  = 1'b0;
    #1;
    chk("async_reset", B, G, R, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("reset_held", B, G, R, 0, 0);
    global_reset = 1'b1;
    step(1, 1, 0, 0, 0); chk("post_reset_mg1", B, G, R, 0, 0);
    step(6, 1, 0, 0, 0); chk("post_reset_mg2", B, G, R, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
